// File: rtl/arm_pkg.sv
// Shared constants, MEM/WB bundle and address check
// for the ARM pipeline memory stage.
package arm_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MEM_DEPTH  = 64;
  localparam int ADDR_BITS  = 6;
  localparam int MEM_BASE   = 1024;

  typedef struct packed {
    logic [31:0] pc;
    logic        wb_en;
    logic        rd_en;
    logic [31:0] alu;
    logic [31:0] data;
    logic [3:0]  dest;
  } mem_wb_t;

  function automatic logic addr_ok(
    input logic [31:0] a,
    input int          base,
    input int          depth
  );
    logic [31:0] lo;
    logic [31:0] hi;
    lo = 32'(base);
    hi = 32'(base + 4 * depth);
    return (a >= lo) && (a < hi) && (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-wide data memory: synchronous write,
// asynchronous read, contents not reset.
module data_memory #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // write port, one word per rising edge
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: address decode, data memory,
// MEM/WB pipeline register and sticky access-error flag.
module mem_stage
  import arm_pkg::*;
#(
  parameter int DATA_WIDTH = arm_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH  = arm_pkg::MEM_DEPTH,
  parameter int ADDR_BITS  = arm_pkg::ADDR_BITS,
  parameter int MEM_BASE   = arm_pkg::MEM_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_Freeze,
  input  logic        i_Flush,
  input  logic [31:0] i_Pc,
  input  logic        i_Sig_Write_Back_Enable,
  input  logic        i_Sig_Memory_Read_Enable,
  input  logic        i_Sig_Memory_Write_Enable,
  input  logic [31:0] i_ALU_Result,
  input  logic [31:0] i_Val_Rm,
  input  logic [3:0]  i_Destination,
  output logic [31:0] o_Pc,
  output logic        o_Sig_Write_Back_Enable,
  output logic        o_Sig_Memory_Read_Enable,
  output logic [31:0] o_ALU_Result,
  output logic [31:0] o_Data_Memory,
  output logic [3:0]  o_Destination,
  output logic        o_Mem_Error
);

  logic [31:0]          off;
  logic [ADDR_BITS-1:0] idx;
  logic                 legal;
  logic                 is_ld;
  logic                 is_st;
  logic                 mem_we;
  logic [31:0]          rdata;

  mem_wb_t wb_d, wb_q;
  logic    err_d, err_q;

  assign off   = i_ALU_Result - 32'(MEM_BASE);
  assign idx   = off[ADDR_BITS+1:2];
  assign legal = addr_ok(i_ALU_Result, MEM_BASE, MEM_DEPTH);
  assign is_st = i_Sig_Memory_Write_Enable;
  assign is_ld = i_Sig_Memory_Read_Enable & ~is_st;

  // a store held in reset never lands
  assign mem_we = is_st & legal & ~i_Freeze
                & ~i_Flush & reset;

  data_memory #(
    .DW    (32),
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_BITS)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx),
    .wdata (i_Val_Rm),
    .rdata (rdata)
  );

  // next MEM/WB contents and error flag
  always_comb begin
    wb_d  = wb_q;
    err_d = err_q;
    if (!i_Freeze) begin
      wb_d.pc  = i_Pc;
      wb_d.alu = i_ALU_Result;
      if (i_Flush) begin
        wb_d.wb_en = 1'b0;
        wb_d.rd_en = 1'b0;
        wb_d.dest  = 4'd0;
        wb_d.data  = '0;
      end else begin
        wb_d.wb_en = i_Sig_Write_Back_Enable;
        wb_d.rd_en = is_ld;
        wb_d.dest  = i_Destination;
        wb_d.data  = (is_ld & legal) ? rdata : '0;
        if ((is_ld | is_st) & ~legal) err_d = 1'b1;
      end
    end
  end

  // MEM/WB register and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      err_q <= err_d;
    end
  end

  assign o_Pc                     = wb_q.pc;
  assign o_Sig_Write_Back_Enable  = wb_q.wb_en;
  assign o_Sig_Memory_Read_Enable = wb_q.rd_en;
  assign o_ALU_Result             = wb_q.alu;
  assign o_Data_Memory            = wb_q.data;
  assign o_Destination            = wb_q.dest;
  assign o_Mem_Error              = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a
// word-array reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        frz, fls;
  logic [31:0] pc;
  logic        wbe, rde, wre;
  logic [31:0] alu, vrm;
  logic [3:0]  dst;
  logic [31:0] o_pc, o_alu, o_data;
  logic        o_wb, o_rd, o_err;
  logic [3:0]  o_dst;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] e_pc, e_alu, e_data;
  logic        e_wb, e_rd, e_err;
  logic [3:0]  e_dst;
  logic [31:0] saved;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                       (clk),
    .reset                     (reset),
    .i_Freeze                  (frz),
    .i_Flush                   (fls),
    .i_Pc                      (pc),
    .i_Sig_Write_Back_Enable   (wbe),
    .i_Sig_Memory_Read_Enable  (rde),
    .i_Sig_Memory_Write_Enable (wre),
    .i_ALU_Result              (alu),
    .i_Val_Rm                  (vrm),
    .i_Destination             (dst),
    .o_Pc                      (o_pc),
    .o_Sig_Write_Back_Enable   (o_wb),
    .o_Sig_Memory_Read_Enable  (o_rd),
    .o_ALU_Result              (o_alu),
    .o_Data_Memory             (o_data),
    .o_Destination             (o_dst),
    .o_Mem_Error               (o_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return a >= 1024 && a < 1024 + 4 * 64
        && a % 4 == 0;
  endfunction

  task automatic model();
    int i;
    bit ok;
    if (frz) return;
    ok = legal(alu);
    i  = ok ? int'((alu - 1024) / 4) : 0;
    e_pc  = pc;
    e_alu = alu;
    if (fls) begin
      e_wb = 0; e_rd = 0; e_dst = 0; e_data = 0;
      return;
    end
    e_wb  = wbe;
    e_dst = dst;
    e_rd  = rde && !wre;
    e_data = (e_rd && ok) ? ref_mem[i] : 32'd0;
    if ((rde || wre) && !ok) e_err = 1;
    if (wre && ok) ref_mem[i] = vrm;
  endtask

  task automatic check_all();
    chk("pc",   o_pc,   e_pc);
    chk("wb",   32'(o_wb),  32'(e_wb));
    chk("rd",   32'(o_rd),  32'(e_rd));
    chk("alu",  o_alu,  e_alu);
    chk("data", o_data, e_data);
    chk("dst",  32'(o_dst), 32'(e_dst));
    chk("err",  32'(o_err), 32'(e_err));
  endtask

  task automatic cyc();
    model();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit r, input bit w,
                       input bit b,
                       input logic [31:0] a,
                       input logic [31:0] v,
                       input logic [3:0] d);
    pc  = $urandom;
    rde = r; wre = w; wbe = b;
    alu = a; vrm = v; dst = d;
  endtask

  function automatic logic [31:0] rnd_addr(input bit bad);
    int k;
    if (!bad) return 32'(1024 + 4 * $urandom_range(0, 63));
    k = $urandom_range(0, 3);
    case (k)
      0: return 32'(1024 + 4 * $urandom_range(0, 63)
                 + $urandom_range(1, 3));
      1: return 32'($urandom_range(0, 1023));
      2: return 32'(1280 + 4 * $urandom_range(0, 100));
      default: return 32'(1024 + 4 * $urandom_range(0, 63));
    endcase
  endfunction

  task automatic clear_model();
    e_pc = 0; e_alu = 0; e_data = 0;
    e_wb = 0; e_rd = 0; e_err = 0; e_dst = 0;
  endtask

  initial begin
    reset = 0;
    frz = 0; fls = 0;
    drive(0, 0, 0, 0, 0, 0);
    clear_model();
    #12;
    check_all();
    @(negedge clk);
    reset = 1;
    #6;

    for (int i = 0; i < 64; i++) begin
      drive(0, 1, 0, 32'(1024 + 4 * i), $urandom, 0);
      cyc();
    end

    drive(0, 1, 0, 1028, 32'hDEADBEEF, 0);
    cyc();
    drive(1, 0, 1, 1028, 0, 4'd7);
    cyc();
    chk("ldr_beef", o_data, 32'hDEADBEEF);
    chk("ldr_rd", 32'(o_rd), 1);

    drive(0, 0, 1, 32'h55, 0, 4'd3);
    cyc();
    chk("alu_55", o_alu, 32'h55);
    chk("alu_dst", 32'(o_dst), 3);

    saved = ref_mem[2];
    drive(0, 1, 1, 1032, 32'hA5A5A5A5, 4'd9);
    frz = 1;
    repeat (3) cyc();
    frz = 0;
    drive(1, 0, 1, 1032, 0, 4'd1);
    cyc();
    chk("frz_mem2", o_data, saved);

    saved = ref_mem[3];
    drive(0, 1, 1, 1036, 32'h12345678, 4'd4);
    fls = 1;
    cyc();
    chk("fls_wb", 32'(o_wb), 0);
    fls = 0;
    drive(1, 0, 1, 1036, 0, 4'd2);
    cyc();
    chk("fls_mem3", o_data, saved);

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), rnd_addr(0),
            $urandom, 4'($urandom));
      frz = ($urandom_range(0, 7) == 0);
      fls = ($urandom_range(0, 7) == 0);
      cyc();
    end
    frz = 0; fls = 0;

    drive(0, 1, 0, 1026, 32'hBAD0BAD0, 0);
    cyc();
    chk("err_mis", 32'(o_err), 1);
    drive(0, 1, 0, 1280, 32'hBAD1BAD1, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("err_stk", 32'(o_err), 1);

    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1),
            rnd_addr($urandom_range(0, 1)),
            $urandom, 4'($urandom));
      frz = ($urandom_range(0, 7) == 0);
      cyc();
    end
    frz = 0;

    drive(0, 0, 0, 0, 0, 0);
    #2;
    reset = 0;
    clear_model();
    #1;
    check_all();
    @(negedge clk);
    reset = 1;
    #6;

    for (int i = 0; i < 64; i++) begin
      drive(1, 0, 1, 32'(1024 + 4 * i), 0, 4'(i));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
